// File: rtl/instr_dec_pkg.sv
// Shared types and defaults for the instruction field decoder.
// Holds the head/extension state encoding and the default field widths.
package instr_dec_pkg;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_EXT  = 1'b1
  } state_t;

  localparam int DEF_OPC_W = 3;
  localparam int DEF_OPR_W = 8;
  localparam int DEF_CNT_W = 16;

  // The all-ones opcode marks a head word that is followed by an extension word
  function automatic int def_ext_opc(input int opc_w);
    return (1 << opc_w) - 1;
  endfunction

endpackage

// File: rtl/instr_field_decoder_opc_onehot.sv
// Combinational one-hot expansion of an opcode field.
module opc_onehot #(
  parameter int OPC_W = 3
) (
  input  logic [OPC_W-1:0]      opc,
  output logic [2**OPC_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[opc] = 1'b1;
  end

endmodule

// File: rtl/instr_field_decoder.sv
// Valid/ready instruction field decoder: splits words into opcode/operand,
// one-hot decodes the opcode and joins head+extension word pairs.
module instr_field_decoder
  import instr_dec_pkg::*;
#(
  parameter int                 OPC_W   = DEF_OPC_W,
  parameter int                 OPR_W   = DEF_OPR_W,
  parameter logic [OPC_W-1:0]   EXT_OPC = OPC_W'(def_ext_opc(OPC_W)),
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPC_W+OPR_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      out_opc,
  output logic [2**OPC_W-1:0]   out_onehot,
  output logic [OPR_W-1:0]      out_opr,
  output logic [OPC_W+OPR_W-1:0] out_ext,
  output logic                  out_has_ext,
  output logic [CNT_W-1:0]      dec_count
);

  localparam int IW   = OPC_W + OPR_W;
  localparam int OH_W = 2**OPC_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        head_p0;
  logic                 load, load_ext, cap_head;
  logic                 acc, out_hs;
  logic [IW-1:0]        src_word;
  logic [OPC_W-1:0]     src_opc;
  logic [OH_W-1:0]      src_onehot;

  logic                 vld_p1;
  logic [OPC_W-1:0]     opc_p1;
  logic [OH_W-1:0]      onehot_p1;
  logic [OPR_W-1:0]     opr_p1;
  logic [IW-1:0]        ext_p1;
  logic                 has_ext_p1;
  logic [CNT_W-1:0]     cnt_q;

  assign in_ready = !vld_p1 || out_ready;
  assign acc      = in_valid && in_ready;
  assign out_hs   = vld_p1 && out_ready;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_ext = 1'b0;
    cap_head = 1'b0;
    if (acc) begin
      case (state_q)
        S_HEAD: begin
          if (in_data[IW-1 -: OPC_W] == EXT_OPC) begin
            cap_head = 1'b1;
            state_d  = S_EXT;
          end else begin
            load = 1'b1;
          end
        end
        S_EXT: begin
          load     = 1'b1;
          load_ext = 1'b1;
          state_d  = S_HEAD;
        end
        default: state_d = S_HEAD;
      endcase
    end
  end

  // Stage p0: field selection from either the live word or the captured head
  assign src_word = load_ext ? head_p0 : in_data;
  assign src_opc  = src_word[IW-1 -: OPC_W];

  opc_onehot #(.OPC_W(OPC_W)) u_onehot (
    .opc    (src_opc),
    .onehot (src_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HEAD;
      head_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (cap_head) head_p0 <= in_data;
    end
  end

  // Stage p1: registered decode result and output handshake bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      opc_p1     <= '0;
      onehot_p1  <= '0;
      opr_p1     <= '0;
      ext_p1     <= '0;
      has_ext_p1 <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (load) begin
        vld_p1     <= 1'b1;
        opc_p1     <= src_opc;
        onehot_p1  <= src_onehot;
        opr_p1     <= src_word[OPR_W-1:0];
        ext_p1     <= load_ext ? in_data : '0;
        has_ext_p1 <= load_ext;
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
      if (out_hs) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid   = vld_p1;
  assign out_opc     = opc_p1;
  assign out_onehot  = onehot_p1;
  assign out_opr     = opr_p1;
  assign out_ext     = ext_p1;
  assign out_has_ext = has_ext_p1;
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_instr_field_decoder.sv
// Directed bench for instr_field_decoder: default instance plus a CNT_W=2
// instance for the saturating counter.
module tb_instr_field_decoder;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        in_valid;
  logic [10:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_has_ext;
  logic [2:0]  out_opc;
  logic [7:0]  out_onehot, out_opr;
  logic [10:0] out_ext;
  logic [15:0] dec_count;

  logic        s_in_ready, s_out_valid, s_out_has_ext;
  logic [2:0]  s_out_opc;
  logic [7:0]  s_out_onehot, s_out_opr;
  logic [10:0] s_out_ext;
  logic [1:0]  s_dec_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_field_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opc(out_opc), .out_onehot(out_onehot), .out_opr(out_opr),
    .out_ext(out_ext), .out_has_ext(out_has_ext), .dec_count(dec_count)
  );

  instr_field_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opc(s_out_opc), .out_onehot(s_out_onehot), .out_opr(s_out_opr),
    .out_ext(s_out_ext), .out_has_ext(s_out_has_ext), .dec_count(s_dec_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_cnt [5];

  initial begin
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; rst2 = 1'b1;
    in_valid = 1'b1; in_data = 11'h7FF; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dec_count", dec_count, 0);
    chk("rst_out_opc", out_opc, 0);
    chk("rst_out_onehot", out_onehot, 0);
    chk("rst_out_has_ext", out_has_ext, 0);

    // single word; also proves nothing was captured during reset
    rst = 1'b0; in_data = 11'h2A5;
    tick();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_opc", out_opc, 3'd2);
    chk("single_opr", out_opr, 8'hA5);
    chk("single_onehot", out_onehot, 8'h04);
    chk("single_has_ext", out_has_ext, 0);
    chk("single_ext", out_ext, 0);
    tick();
    chk("single_drained", out_valid, 0);
    chk("single_count", dec_count, 1);
    chk("single_opr_hold", out_opr, 8'hA5);

    // extended instruction
    in_valid = 1'b1; in_data = 11'h7FF;
    tick();
    chk("ext_head_novalid", out_valid, 0);
    in_data = 11'h123;
    tick();
    in_valid = 1'b0;
    chk("ext_valid", out_valid, 1);
    chk("ext_opc", out_opc, 3'd7);
    chk("ext_opr", out_opr, 8'hFF);
    chk("ext_onehot", out_onehot, 8'h80);
    chk("ext_word", out_ext, 11'h123);
    chk("ext_has_ext", out_has_ext, 1);
    tick();
    chk("ext_count", dec_count, 2);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 11'h101;
    tick();
    in_data = 11'h202;
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_opc", out_opc, 3'd1);
    chk("bp_first_opr", out_opr, 8'h01);
    chk("bp_in_ready_low", in_ready, 0);
    tick(); tick();
    chk("bp_hold_opr", out_opr, 8'h01);
    chk("bp_hold_opc", out_opc, 3'd1);
    chk("bp_hold_count", dec_count, 2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_up", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_opc", out_opc, 3'd2);
    chk("bp_second_opr", out_opr, 8'h02);
    chk("bp_count_mid", dec_count, 3);
    tick();
    chk("bp_drained", out_valid, 0);
    chk("bp_count_end", dec_count, 4);

    // reset mid-extension discards the head
    in_valid = 1'b1; in_data = 11'h700;
    tick();
    chk("rx_head_novalid", out_valid, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 11'h123;
    tick();
    chk("rx_valid", out_valid, 1);
    chk("rx_opc", out_opc, 3'd1);
    chk("rx_opr", out_opr, 8'h23);
    chk("rx_has_ext", out_has_ext, 0);
    chk("rx_ext", out_ext, 0);
    chk("rx_count", dec_count, 0);

    // reset wins over a simultaneous handshake and accept
    in_data = 11'h055;
    rst = 1'b1;
    tick();
    chk("rprio_valid", out_valid, 0);
    chk("rprio_count", dec_count, 0);
    chk("rprio_opr", out_opr, 0);

    // counter saturation on the CNT_W=2 instance
    rst = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 11'h010 + 11'(i);
      tick();
      if (i > 0) chk($sformatf("sat_count_%0d", i - 1), s_dec_count, exp_cnt[i - 1]);
    end
    in_valid = 1'b0;
    chk("sat_last_opr", s_out_opr, 8'h14);
    tick();
    chk("sat_count_4", s_dec_count, exp_cnt[4]);
    chk("sat_drained", s_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
